time_set_ctrl_57: RTL and testbench
===================================

# time_set_ctrl_57

Button-driven mode controller that sequences the digital clock's display and time-setting path. It decodes mode, increment, decrement and week pulses into a registered state machine. The state machine drives the display's mode, blink and digit-pair select inputs, holds an edit copy of hour, minute and second, and commits that copy to the timekeeping counter with a one-cycle load pulse. It sits between the debounced button front-end and the display / timekeeper pair.

## Interface
Parameters:
- TIMEOUT_CYC, 10000: idle cycles in any set state before abandoning the edit.
- WEEK_CYC, 2000: cycles the week-day view is held after entry.

Ports:
- clk_57  in  1  system clock; the only clock.
- rst_57  in  1  reset, synchronous and active-high.
- btn_mode_57  in  1  single-cycle pulse: enter set mode or advance through it.
- btn_inc_57  in  1  single-cycle pulse: increment the field being edited.
- btn_dec_57  in  1  single-cycle pulse: decrement the field being edited.
- btn_week_57  in  1  single-cycle pulse: toggle the week-day view.
- sec_57, min_57, hour_57  in  7 each  live time from the timekeeper, binary.
- disp_sec_57, disp_min_57, disp_hour_57  out  7 each  time shown on the display: the edit registers while pause_57=1, otherwise the live inputs (combinational pass-through).
- set_sec_57, set_min_57, set_hour_57  out  7 each  edit registers, i.e. the values to commit.
- load_57  out  1  one-cycle commit strobe to the timekeeper.
- pause_57  out  1  freezes the timekeeper while editing.
- time_model_57  out  1  display time mode; 1 in every state.
- shine_e_57  out  1  display blink enable.
- select_57  out  3  blink pair, one-hot: 100 = hour digits, 010 = minute digits, 001 = second digits, 000 = none.
- week_e_57  out  1  display week-day view.

## Operation
States: NORM, S_HOUR, S_MIN, S_SEC, WEEK. All state transitions are registered.

- **NORM:** shine_e=0, select=000, week_e=0.
  - btn_mode: edit regs <= live sec/min/hour on the same edge, then go to S_HOUR.
  - btn_week (without btn_mode): go to WEEK.
  - btn_mode wins over btn_week when both arrive together.
- **S_HOUR / S_MIN / S_SEC:** shine_e=1, select=100 / 010 / 001 respectively, pause=1.
  - btn_mode advances S_HOUR -> S_MIN -> S_SEC.
  - btn_mode in S_SEC goes to NORM and asserts load_57 for one cycle.
- **Field edits (set states only):**
  - btn_inc and btn_dec act on the selected field.
  - Hour wraps in 0..23. Minute and second wrap in 0..59.
  - inc at max -> 0. dec at 0 -> max.
  - A captured out-of-range value goes to 0 on inc and to max on dec.
- **Simultaneous button events:**
  - btn_inc and btn_dec in the same cycle: both ignored.
  - btn_mode with inc or dec in the same cycle: mode acts, the edit is dropped.
  - btn_week in a set state: ignored.
- **Idle timeout:** an idle counter restarts on state entry and on any button pulse. After TIMEOUT_CYC consecutive idle cycles in a set state, go to NORM with no load; the edit is discarded.
- **WEEK:** week_e=1, shine_e=0, select=000.
  - Returns to NORM after WEEK_CYC cycles.
  - Returns to NORM immediately on btn_week or btn_mode; btn_mode does not enter set mode from WEEK.
  - inc and dec are ignored.
- **Signal derivation:**
  - pause_57 = (state is a set state) | load_57.
  - set_* hold their value in NORM and WEEK until the next capture.

## Timing
- **Reset values:**
  - state=NORM, time_model=1, shine_e=0, select=000, week_e=0, pause=0, load=0.
  - set_*=0, both counters=0.
- **Reset mid-operation:** reset during any state returns to NORM on the next edge with no load and the edit discarded.
- **Latency:** outputs are registered. A button pulse in cycle N is reflected in state, outputs and edit regs in cycle N+1.
- **Commit cycle:**
  - load_57=1 only in the cycle after btn_mode in S_SEC.
  - In that cycle, set_* are stable and pause_57 is still 1.
  - pause_57 falls one cycle later.
  - The timekeeper gives load priority over its own increment.
- **Timeout:** occurs exactly TIMEOUT_CYC cycles after the last button pulse or state entry.
- **Week duration:** WEEK lasts exactly WEEK_CYC cycles when no button is pressed.
- **Counter width:** ceil(log2(max(TIMEOUT_CYC, WEEK_CYC))) bits. Counters saturate rather than wrap.

## Test plan
- **Full edit and commit:**
  - Stimulus: live time 12:34:56; mode, inc x2, mode, dec, mode, inc, mode.
  - Required: select sequence 100, 010, 001, 000; load pulses for exactly 1 cycle with set = 14:33:57; pause drops 1 cycle after load.
- **Wrap boundaries:**
  - Hour 23 + inc -> 0.
  - Minute 0 + dec -> 59.
  - Second 59 + inc -> 0.
  - Captured hour 30 + dec -> 23.
- **Simultaneous events:**
  - inc+dec in the same cycle: field unchanged.
  - mode+inc in S_HOUR: moves to S_MIN with hour unchanged.
  - mode+week in NORM: enters S_HOUR.
- **Timeout:**
  - Stimulus: TIMEOUT_CYC=16; enter S_MIN, press inc at idle count 10, then go idle.
  - Required: NORM exactly 16 cycles after the inc; load never asserted; disp_* follow the live inputs again.
- **Week view:**
  - Stimulus: WEEK_CYC=8; btn_week in NORM.
  - Required: week_e=1 for exactly 8 cycles.
  - Second case: btn_mode at cycle 3 of WEEK returns to NORM, not S_HOUR.
- **Mid-operation reset:**
  - Stimulus: assert rst_57 in S_SEC with edited values.
  - Required: next cycle state=NORM, all outputs at their reset values, no load.

Source files
------------

// File: rtl/time_set_ctrl_57.sv
`default_nettype none
// ============================================================================
// Module  : time_set_ctrl_57
// Brief   : Button-driven mode/time-set controller between the debounced
//           buttons and the display/timekeeper pair.
// Revision: 1.0 - initial release
// ============================================================================
module time_set_ctrl_57 #(
    parameter int TIMEOUT_CYC = 10000,
    parameter int WEEK_CYC    = 2000
) (
    input  logic       clk_57,
    input  logic       rst_57,
    input  logic       btn_mode_57,
    input  logic       btn_inc_57,
    input  logic       btn_dec_57,
    input  logic       btn_week_57,
    input  logic [6:0] sec_57,
    input  logic [6:0] min_57,
    input  logic [6:0] hour_57,
    output logic [6:0] disp_sec_57,
    output logic [6:0] disp_min_57,
    output logic [6:0] disp_hour_57,
    output logic [6:0] set_sec_57,
    output logic [6:0] set_min_57,
    output logic [6:0] set_hour_57,
    output logic       load_57,
    output logic       pause_57,
    output logic       time_model_57,
    output logic       shine_e_57,
    output logic [2:0] select_57,
    output logic       week_e_57
);

    localparam int c_CNT_MAX = (TIMEOUT_CYC > WEEK_CYC) ? TIMEOUT_CYC : WEEK_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WK_LAST = c_CNT_W'(WEEK_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = '1;

    localparam logic [6:0] c_HOUR_MAX = 7'd23;
    localparam logic [6:0] c_MS_MAX   = 7'd59;

    localparam logic [2:0] c_ST_NORM = 3'd0;
    localparam logic [2:0] c_ST_HOUR = 3'd1;
    localparam logic [2:0] c_ST_MIN  = 3'd2;
    localparam logic [2:0] c_ST_SEC  = 3'd3;
    localparam logic [2:0] c_ST_WEEK = 3'd4;

    logic [2:0]         r_state;
    logic               r_load;
    logic [6:0]         r_set_hour;
    logic [6:0]         r_set_min;
    logic [6:0]         r_set_sec;
    logic [c_CNT_W-1:0] r_idle;
    logic [c_CNT_W-1:0] r_wcnt;

    logic [2:0]         w_state_nx;
    logic               w_load_nx;
    logic [6:0]         w_hour_nx;
    logic [6:0]         w_min_nx;
    logic [6:0]         w_sec_nx;
    logic [c_CNT_W-1:0] w_idle_nx;
    logic [c_CNT_W-1:0] w_wcnt_nx;
    logic               w_any;
    logic               w_edit;
    logic               w_set_st;

    // Wrapping step; values captured above the field maximum snap to 0 / max.
    function automatic logic [6:0] f_step(input logic [6:0] v,
                                          input logic [6:0] vmax,
                                          input logic       up);
        logic [6:0] res;
        if (up) begin
            res = (v >= vmax) ? 7'd0 : v + 7'd1;
        end else begin
            res = ((v == 7'd0) || (v > vmax)) ? vmax : v - 7'd1;
        end
        return res;
    endfunction

    assign w_any    = btn_mode_57 | btn_inc_57 | btn_dec_57 | btn_week_57;
    assign w_edit   = (btn_inc_57 ^ btn_dec_57) & ~btn_mode_57;
    assign w_set_st = (r_state == c_ST_HOUR) || (r_state == c_ST_MIN) ||
                      (r_state == c_ST_SEC);

    always_comb begin
        w_state_nx = r_state;
        w_load_nx  = 1'b0;
        w_hour_nx  = r_set_hour;
        w_min_nx   = r_set_min;
        w_sec_nx   = r_set_sec;
        w_idle_nx  = r_idle;
        w_wcnt_nx  = r_wcnt;

        case (r_state)
            c_ST_NORM: begin
                w_idle_nx = '0;
                w_wcnt_nx = '0;
                if (btn_mode_57) begin
                    w_hour_nx  = hour_57;
                    w_min_nx   = min_57;
                    w_sec_nx   = sec_57;
                    w_state_nx = c_ST_HOUR;
                end else if (btn_week_57) begin
                    w_state_nx = c_ST_WEEK;
                end
            end

            c_ST_HOUR, c_ST_MIN, c_ST_SEC: begin
                if (w_any) begin
                    w_idle_nx = '0;
                end else if (r_idle != c_CNT_SAT) begin
                    w_idle_nx = r_idle + 1'b1;
                end

                if (btn_mode_57) begin
                    case (r_state)
                        c_ST_HOUR: w_state_nx = c_ST_MIN;
                        c_ST_MIN:  w_state_nx = c_ST_SEC;
                        default: begin
                            w_state_nx = c_ST_NORM;
                            w_load_nx  = 1'b1;
                        end
                    endcase
                end else if (!w_any && (r_idle == c_TO_LAST)) begin
                    w_state_nx = c_ST_NORM;
                end else if (w_edit) begin
                    case (r_state)
                        c_ST_HOUR: w_hour_nx = f_step(r_set_hour, c_HOUR_MAX, btn_inc_57);
                        c_ST_MIN:  w_min_nx  = f_step(r_set_min,  c_MS_MAX,   btn_inc_57);
                        default:   w_sec_nx  = f_step(r_set_sec,  c_MS_MAX,   btn_inc_57);
                    endcase
                end
            end

            c_ST_WEEK: begin
                w_idle_nx = '0;
                if (btn_mode_57 || btn_week_57 || (r_wcnt == c_WK_LAST)) begin
                    w_state_nx = c_ST_NORM;
                end else if (r_wcnt != c_CNT_SAT) begin
                    w_wcnt_nx = r_wcnt + 1'b1;
                end
            end

            default: begin
                w_state_nx = c_ST_NORM;
                w_idle_nx  = '0;
                w_wcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_57) begin
        if (rst_57) begin
            r_state    <= c_ST_NORM;
            r_load     <= 1'b0;
            r_set_hour <= 7'd0;
            r_set_min  <= 7'd0;
            r_set_sec  <= 7'd0;
            r_idle     <= '0;
            r_wcnt     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_load     <= w_load_nx;
            r_set_hour <= w_hour_nx;
            r_set_min  <= w_min_nx;
            r_set_sec  <= w_sec_nx;
            r_idle     <= w_idle_nx;
            r_wcnt     <= w_wcnt_nx;
        end
    end

    // Pause stays high through the commit cycle so the load lands on a frozen counter.
    assign pause_57      = w_set_st | r_load;
    assign load_57       = r_load;
    assign time_model_57 = 1'b1;
    assign shine_e_57    = w_set_st;
    assign week_e_57     = (r_state == c_ST_WEEK);
    assign select_57     = {(r_state == c_ST_HOUR), (r_state == c_ST_MIN),
                            (r_state == c_ST_SEC)};

    assign set_hour_57  = r_set_hour;
    assign set_min_57   = r_set_min;
    assign set_sec_57   = r_set_sec;
    assign disp_hour_57 = pause_57 ? r_set_hour : hour_57;
    assign disp_min_57  = pause_57 ? r_set_min  : min_57;
    assign disp_sec_57  = pause_57 ? r_set_sec  : sec_57;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl_57.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_set_ctrl_57
// Brief   : Self-checking bench for time_set_ctrl_57 (model + directed vectors).
// Revision: 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl_57;

    localparam int T_TO = 16;
    localparam int T_WK = 8;

    logic       clk_57 = 1'b0;
    logic       rst_57, btn_mode_57, btn_inc_57, btn_dec_57, btn_week_57;
    logic [6:0] sec_57, min_57, hour_57;
    logic [6:0] disp_sec_57, disp_min_57, disp_hour_57;
    logic [6:0] set_sec_57, set_min_57, set_hour_57;
    logic       load_57, pause_57, time_model_57, shine_e_57, week_e_57;
    logic [2:0] select_57;

    time_set_ctrl_57 #(.TIMEOUT_CYC(T_TO), .WEEK_CYC(T_WK)) dut (
        .clk_57(clk_57), .rst_57(rst_57),
        .btn_mode_57(btn_mode_57), .btn_inc_57(btn_inc_57),
        .btn_dec_57(btn_dec_57), .btn_week_57(btn_week_57),
        .sec_57(sec_57), .min_57(min_57), .hour_57(hour_57),
        .disp_sec_57(disp_sec_57), .disp_min_57(disp_min_57), .disp_hour_57(disp_hour_57),
        .set_sec_57(set_sec_57), .set_min_57(set_min_57), .set_hour_57(set_hour_57),
        .load_57(load_57), .pause_57(pause_57), .time_model_57(time_model_57),
        .shine_e_57(shine_e_57), .select_57(select_57), .week_e_57(week_e_57)
    );

    always #5 clk_57 = ~clk_57;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: 0=normal, 1=hour, 2=minute, 3=second, 4=week view
    int m_st, m_h, m_m, m_s, m_quiet;
    bit m_load, m_any;

    function automatic int bump(input int v, input int mx, input bit up);
        if (up) return (v > mx) ? 0 : (v + 1) % (mx + 1);
        else    return (v > mx) ? mx : (v + mx) % (mx + 1);
    endfunction

    always @(posedge clk_57) begin
        m_load = 1'b0;
        m_any  = btn_mode_57 | btn_inc_57 | btn_dec_57 | btn_week_57;
        if (rst_57) begin
            m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_quiet = 0;
        end else if (m_st == 0) begin
            if (btn_mode_57) begin
                m_h = hour_57; m_m = min_57; m_s = sec_57; m_st = 1; m_quiet = 0;
            end else if (btn_week_57) begin
                m_st = 4; m_quiet = 0;
            end
        end else if (m_st == 4) begin
            m_quiet++;
            if (btn_mode_57 || btn_week_57 || m_quiet >= T_WK) m_st = 0;
        end else begin
            if (btn_mode_57) begin
                if (m_st == 3) begin m_load = 1'b1; m_st = 0; end
                else m_st = m_st + 1;
                m_quiet = 0;
            end else if (m_any) begin
                m_quiet = 0;
                if (btn_inc_57 != btn_dec_57) begin
                    if (m_st == 1)      m_h = bump(m_h, 23, btn_inc_57);
                    else if (m_st == 2) m_m = bump(m_m, 59, btn_inc_57);
                    else                m_s = bump(m_s, 59, btn_inc_57);
                end
            end else begin
                m_quiet++;
                if (m_quiet >= T_TO) m_st = 0;
            end
        end
    end

    always @(negedge clk_57) begin
        if (chk_en) begin
            bit p;
            p = (m_st >= 1 && m_st <= 3) || m_load;
            chk("select", select_57, (m_st == 1) ? 4 : (m_st == 2) ? 2 : (m_st == 3) ? 1 : 0);
            chk("shine_e", shine_e_57, (m_st >= 1 && m_st <= 3));
            chk("week_e", week_e_57, (m_st == 4));
            chk("load", load_57, m_load);
            chk("pause", pause_57, p);
            chk("time_model", time_model_57, 1);
            chk("set_hour", set_hour_57, m_h);
            chk("set_min", set_min_57, m_m);
            chk("set_sec", set_sec_57, m_s);
            chk("disp_hour", disp_hour_57, p ? m_h : int'(hour_57));
            chk("disp_min", disp_min_57, p ? m_m : int'(min_57));
            chk("disp_sec", disp_sec_57, p ? m_s : int'(sec_57));
        end
    end

    task automatic step();
        @(posedge clk_57);
        #1;
    endtask

    task automatic press(input bit m, input bit i, input bit d, input bit w);
        btn_mode_57 = m; btn_inc_57 = i; btn_dec_57 = d; btn_week_57 = w;
        step();
        btn_mode_57 = 0; btn_inc_57 = 0; btn_dec_57 = 0; btn_week_57 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic live(input int h, input int m, input int s);
        hour_57 = 7'(h); min_57 = 7'(m); sec_57 = 7'(s);
    endtask

    initial begin
        int  n;
        bit  saw_load;
        rst_57 = 1; btn_mode_57 = 0; btn_inc_57 = 0; btn_dec_57 = 0; btn_week_57 = 0;
        live(12, 34, 56);
        step();
        chk_en = 1'b1;
        idle(2);
        chk("rst_select", select_57, 0);
        chk("rst_pause", pause_57, 0);
        chk("rst_load", load_57, 0);
        chk("rst_set_hour", set_hour_57, 0);
        chk("rst_time_model", time_model_57, 1);
        rst_57 = 0;
        idle(1);

        // full edit and commit: 12:34:56 -> 14:33:57
        press(1, 0, 0, 0);
        chk("edit_sel_hour", select_57, 3'b100);
        chk("capture_min", set_min_57, 34);
        press(0, 1, 0, 0); press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        chk("edit_sel_min", select_57, 3'b010);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        chk("edit_sel_sec", select_57, 3'b001);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        chk("commit_load", load_57, 1);
        chk("commit_pause", pause_57, 1);
        chk("commit_sel", select_57, 3'b000);
        chk("commit_hour", set_hour_57, 14);
        chk("commit_min", set_min_57, 33);
        chk("commit_sec", set_sec_57, 57);
        idle(1);
        chk("post_load", load_57, 0);
        chk("post_pause", pause_57, 0);
        idle(2);

        // wrap boundaries
        live(23, 0, 59);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        chk("wrap_hour_inc", set_hour_57, 0);
        press(1, 0, 0, 0); press(0, 0, 1, 0);
        chk("wrap_min_dec", set_min_57, 59);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        chk("wrap_sec_inc", set_sec_57, 0);
        press(1, 0, 0, 0);
        idle(2);

        // out-of-range capture, simultaneous buttons, then timeout from S_MIN
        live(30, 10, 20);
        press(1, 0, 0, 0); press(0, 0, 1, 0);
        chk("oor_hour_dec", set_hour_57, 23);
        press(0, 1, 1, 0);
        chk("incdec_same", set_hour_57, 23);
        press(1, 1, 0, 0);
        chk("modeinc_sel", select_57, 3'b010);
        chk("modeinc_hour", set_hour_57, 23);
        chk("modeinc_min", set_min_57, 10);
        idle(10);
        press(0, 1, 0, 0);
        chk("to_min_inc", set_min_57, 11);
        n = 0; saw_load = 0;
        while (select_57 != 3'b000 && n < 40) begin
            step();
            n++;
            if (load_57) saw_load = 1;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_no_load", saw_load, 0);
        chk("timeout_disp_hour", disp_hour_57, 30);
        chk("timeout_disp_min", disp_min_57, 10);
        idle(2);

        // mode + week in NORM enters set mode
        press(1, 0, 0, 1);
        chk("modeweek_sel", select_57, 3'b100);
        chk("modeweek_week", week_e_57, 0);
        press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
        idle(2);

        // week view duration
        press(0, 0, 0, 1);
        n = 0;
        while (week_e_57 && n < 40) begin
            n++;
            step();
        end
        chk("week_cycles", n, 8);
        idle(2);

        // mode during week view leaves to NORM, not set mode
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        press(0, 0, 0, 0);
        press(1, 0, 0, 0);
        chk("week_mode_exit", week_e_57, 0);
        chk("week_mode_sel", select_57, 3'b000);
        idle(2);
        chk("week_mode_stay", select_57, 3'b000);

        // reset in the middle of an edit
        live(5, 6, 7);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
        chk("pre_rst_sel", select_57, 3'b001);
        chk("pre_rst_sec", set_sec_57, 8);
        rst_57 = 1;
        step();
        chk("mid_rst_sel", select_57, 0);
        chk("mid_rst_shine", shine_e_57, 0);
        chk("mid_rst_pause", pause_57, 0);
        chk("mid_rst_load", load_57, 0);
        chk("mid_rst_hour", set_hour_57, 0);
        chk("mid_rst_sec", set_sec_57, 0);
        chk("mid_rst_disp", disp_hour_57, 5);
        rst_57 = 0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
